// File: rtl/imm_decode_stage_pkg.sv
// rtl/imm_decode_stage_pkg.sv - shared immediate-format and opcode constants
package imm_decode_stage_pkg;

    // Immediate format codes carried on the 3-bit imm_src bus
    typedef enum logic [2:0] {
        IT = 3'd0,
        ST = 3'd1,
        BT = 3'd2,
        JT = 3'd3,
        UT = 3'd4,
        NT = 3'd5
    } imm_src_e;

    // Occupancy of the two-entry skid buffer
    typedef enum logic [1:0] {
        BUF_EMPTY = 2'd0,
        BUF_ONE   = 2'd1,
        BUF_TWO   = 2'd2
    } buf_state_e;

    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;

    // True for every opcode in the decode map, including the no-immediate ones
    function automatic logic is_known_opcode(input logic [6:0] op);
        case (op)
            OP_IMM, OP_LOAD, OP_JALR, OP_SYSTEM,
            OP_STORE, OP_BRANCH, OP_JAL,
            OP_AUIPC, OP_LUI, OP_REG, OP_FENCE: is_known_opcode = 1'b1;
            default:                            is_known_opcode = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/imm_gen.sv
// rtl/imm_gen.sv - combinational opcode classifier and immediate builder (optional IMM_DECODE_ILLEGAL_EN)
module imm_gen
    import imm_decode_stage_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     instr_i,
    output logic [2:0]      imm_src_o,
    output logic [XLEN-1:0] imm_o,
    output logic            illegal_o
);

    imm_src_e    src;
    logic [31:0] imm32;

    // Classify the opcode and assemble the 32-bit sign-extended immediate
    always_comb begin
        src   = NT;
        imm32 = '0;
        case (instr_i[6:0])
            OP_IMM, OP_LOAD, OP_JALR, OP_SYSTEM: begin
                src   = IT;
                imm32 = {{20{instr_i[31]}}, instr_i[31:20]};
            end
            OP_STORE: begin
                src   = ST;
                imm32 = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
            end
            OP_BRANCH: begin
                src   = BT;
                imm32 = {{19{instr_i[31]}}, instr_i[31], instr_i[7],
                         instr_i[30:25], instr_i[11:8], 1'b0};
            end
            OP_JAL: begin
                src   = JT;
                imm32 = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12],
                         instr_i[20], instr_i[30:21], 1'b0};
            end
            OP_AUIPC, OP_LUI: begin
                src   = UT;
                imm32 = {instr_i[31:12], 12'b0};
            end
            default: begin
                src   = NT;
                imm32 = '0;
            end
        endcase
    end

    assign imm_src_o = src;
    // Bit 31 is the sign for every format, so widening to XLEN is a plain sign-extension
    assign imm_o     = XLEN'($signed(imm32));

`ifdef IMM_DECODE_ILLEGAL_EN
    assign illegal_o = !is_known_opcode(instr_i[6:0]) || (instr_i[1:0] != 2'b11);
`else
    assign illegal_o = 1'b0;
`endif

endmodule

// File: rtl/imm_decode_stage.sv
// rtl/imm_decode_stage.sv - registered immediate decode stage with 2-entry skid buffer (optional IMM_DECODE_ILLEGAL_EN)
module imm_decode_stage
    import imm_decode_stage_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int PC_W = XLEN
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_flush,
    input  logic            i_valid,
    output logic            o_ready,
    input  logic [31:0]     i_instr,
    input  logic [PC_W-1:0] i_pc,
    output logic            o_valid,
    input  logic            i_ready,
    output logic [31:0]     o_instr,
    output logic [PC_W-1:0] o_pc,
    output logic [2:0]      o_imm_src,
    output logic [XLEN-1:0] o_imm,
    output logic            o_illegal
);

    logic [2:0]      dec_src;
    logic [XLEN-1:0] dec_imm;
    logic            dec_ill;

    imm_gen #(.XLEN(XLEN)) u_imm_gen (
        .instr_i   (i_instr),
        .imm_src_o (dec_src),
        .imm_o     (dec_imm),
        .illegal_o (dec_ill)
    );

    buf_state_e      state_q, state_d;
    logic            ready_q;

    // Head entry drives the outputs; skid entry holds the second accepted instruction
    logic [31:0]     head_instr_q, head_instr_d;
    logic [PC_W-1:0] head_pc_q, head_pc_d;
    logic [2:0]      head_src_q, head_src_d;
    logic [XLEN-1:0] head_imm_q, head_imm_d;
    logic            head_ill_q, head_ill_d;

    logic [31:0]     skid_instr_q, skid_instr_d;
    logic [PC_W-1:0] skid_pc_q, skid_pc_d;
    logic [2:0]      skid_src_q, skid_src_d;
    logic [XLEN-1:0] skid_imm_q, skid_imm_d;
    logic            skid_ill_q, skid_ill_d;

    logic accept;
    logic drain;

    assign o_valid = (state_q != BUF_EMPTY);
    assign o_ready = ready_q;
    assign accept  = i_valid & ready_q;
    assign drain   = o_valid & i_ready;

    // Next occupancy and entry movement; flush wins over accept and drain
    always_comb begin
        state_d      = state_q;
        head_instr_d = head_instr_q;
        head_pc_d    = head_pc_q;
        head_src_d   = head_src_q;
        head_imm_d   = head_imm_q;
        head_ill_d   = head_ill_q;
        skid_instr_d = skid_instr_q;
        skid_pc_d    = skid_pc_q;
        skid_src_d   = skid_src_q;
        skid_imm_d   = skid_imm_q;
        skid_ill_d   = skid_ill_q;

        if (i_flush) begin
            state_d = BUF_EMPTY;
        end else begin
            case (state_q)
                BUF_EMPTY: begin
                    if (accept) begin
                        state_d      = BUF_ONE;
                        head_instr_d = i_instr;
                        head_pc_d    = i_pc;
                        head_src_d   = dec_src;
                        head_imm_d   = dec_imm;
                        head_ill_d   = dec_ill;
                    end
                end
                BUF_ONE: begin
                    if (accept && drain) begin
                        head_instr_d = i_instr;
                        head_pc_d    = i_pc;
                        head_src_d   = dec_src;
                        head_imm_d   = dec_imm;
                        head_ill_d   = dec_ill;
                    end else if (accept) begin
                        state_d      = BUF_TWO;
                        skid_instr_d = i_instr;
                        skid_pc_d    = i_pc;
                        skid_src_d   = dec_src;
                        skid_imm_d   = dec_imm;
                        skid_ill_d   = dec_ill;
                    end else if (drain) begin
                        state_d = BUF_EMPTY;
                    end
                end
                BUF_TWO: begin
                    // o_ready is low here, so only a drain can happen
                    if (drain) begin
                        state_d      = BUF_ONE;
                        head_instr_d = skid_instr_q;
                        head_pc_d    = skid_pc_q;
                        head_src_d   = skid_src_q;
                        head_imm_d   = skid_imm_q;
                        head_ill_d   = skid_ill_q;
                    end
                end
                default: state_d = BUF_EMPTY;
            endcase
        end
    end

    // Occupancy and registered ready; ready stays low throughout reset
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q <= BUF_EMPTY;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ready_q <= (state_d != BUF_TWO);
        end
    end

    // Entry storage
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            head_instr_q <= '0;
            head_pc_q    <= '0;
            head_src_q   <= NT;
            head_imm_q   <= '0;
            head_ill_q   <= 1'b0;
            skid_instr_q <= '0;
            skid_pc_q    <= '0;
            skid_src_q   <= NT;
            skid_imm_q   <= '0;
            skid_ill_q   <= 1'b0;
        end else begin
            head_instr_q <= head_instr_d;
            head_pc_q    <= head_pc_d;
            head_src_q   <= head_src_d;
            head_imm_q   <= head_imm_d;
            head_ill_q   <= head_ill_d;
            skid_instr_q <= skid_instr_d;
            skid_pc_q    <= skid_pc_d;
            skid_src_q   <= skid_src_d;
            skid_imm_q   <= skid_imm_d;
            skid_ill_q   <= skid_ill_d;
        end
    end

    assign o_instr   = head_instr_q;
    assign o_pc      = head_pc_q;
    assign o_imm_src = head_src_q;
    assign o_imm     = head_imm_q;
    assign o_illegal = head_ill_q;

endmodule

// File: tb/tb_imm_decode_stage.sv
// tb/tb_imm_decode_stage.sv - directed self-checking bench for imm_decode_stage
module tb_imm_decode_stage;

    localparam logic [2:0] S_IT = 3'd0;
    localparam logic [2:0] S_ST = 3'd1;
    localparam logic [2:0] S_BT = 3'd2;
    localparam logic [2:0] S_JT = 3'd3;
    localparam logic [2:0] S_UT = 3'd4;
    localparam logic [2:0] S_NT = 3'd5;

`ifdef IMM_DECODE_ILLEGAL_EN
    localparam logic EXP_ILL = 1'b1;
`else
    localparam logic EXP_ILL = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        out_ready;
    logic [31:0] in_instr;
    logic [31:0] in_pc;
    logic        out_valid;
    logic        ds_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic [2:0]  out_src;
    logic [31:0] out_imm;
    logic        out_ill;

    int checks = 0;
    int failures = 0;

    imm_decode_stage #(.XLEN(32), .PC_W(32)) dut (
        .i_clk     (clk),
        .i_rst_n   (rst_n),
        .i_flush   (flush),
        .i_valid   (in_valid),
        .o_ready   (out_ready),
        .i_instr   (in_instr),
        .i_pc      (in_pc),
        .o_valid   (out_valid),
        .i_ready   (ds_ready),
        .o_instr   (out_instr),
        .o_pc      (out_pc),
        .o_imm_src (out_src),
        .o_imm     (out_imm),
        .o_illegal (out_ill)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_chk(input string tag, input logic [31:0] ins, input logic [31:0] pc,
                            input logic [31:0] exp_imm, input logic [2:0] exp_src,
                            input logic exp_ill);
        in_valid = 1'b1;
        in_instr = ins;
        in_pc    = pc;
        step();
        in_valid = 1'b0;
        check({tag, "_valid"}, 64'(out_valid), 64'(1'b1));
        check({tag, "_instr"}, 64'(out_instr), 64'(ins));
        check({tag, "_pc"},    64'(out_pc),    64'(pc));
        check({tag, "_imm"},   64'(out_imm),   64'(exp_imm));
        check({tag, "_src"},   64'(out_src),   64'(exp_src));
        check({tag, "_ill"},   64'(out_ill),   64'(exp_ill));
        step();
        check({tag, "_drained"}, 64'(out_valid), 64'(1'b0));
    endtask

    initial begin
        rst_n    = 1'b0;
        flush    = 1'b0;
        in_valid = 1'b1;
        in_instr = 32'h0050_0093;
        in_pc    = 32'h0000_0100;
        ds_ready = 1'b1;

        // reset held 3 cycles with valid input present
        for (int i = 0; i < 3; i++) begin
            step();
            check("rst_valid", 64'(out_valid), 64'(1'b0));
            check("rst_ready", 64'(out_ready), 64'(1'b0));
        end
        check("rst_imm",   64'(out_imm),   64'h0);
        check("rst_src",   64'(out_src),   64'(S_NT));
        check("rst_ill",   64'(out_ill),   64'h0);
        check("rst_instr", 64'(out_instr), 64'h0);
        check("rst_pc",    64'(out_pc),    64'h0);
        in_valid = 1'b0;
        rst_n    = 1'b1;
        step();
        check("rel_ready", 64'(out_ready), 64'(1'b1));
        check("rel_valid", 64'(out_valid), 64'(1'b0));

        // immediate formats
        send_chk("it_neg", 32'hFFF0_0093, 32'h1000, 32'hFFFF_FFFF, S_IT, 1'b0);
        send_chk("it_pos", 32'h0050_0093, 32'h1004, 32'h0000_0005, S_IT, 1'b0);
        send_chk("st",     32'hFE11_2E23, 32'h1008, 32'hFFFF_FFFC, S_ST, 1'b0);
        send_chk("bt",     32'hFE00_0EE3, 32'h100C, 32'hFFFF_FFFC, S_BT, 1'b0);
        send_chk("jt",     32'hFF9F_F06F, 32'h1010, 32'hFFFF_FFF8, S_JT, 1'b0);
        send_chk("ut",     32'h1234_52B7, 32'h1014, 32'h1234_5000, S_UT, 1'b0);
        send_chk("nt",     32'h0000_0033, 32'h1018, 32'h0000_0000, S_NT, 1'b0);
        send_chk("illop",  32'h0000_007F, 32'h101C, 32'h0000_0000, S_NT, EXP_ILL);

        // back-pressure: A, B buffered, C held off
        ds_ready = 1'b0;
        in_valid = 1'b1;
        in_instr = 32'h0010_0093; in_pc = 32'h2000;
        step();
        check("bp_a_valid", 64'(out_valid), 64'(1'b1));
        check("bp_a_head",  64'(out_instr), 64'h0010_0093);
        check("bp_a_ready", 64'(out_ready), 64'(1'b1));
        in_instr = 32'h0020_0093; in_pc = 32'h2004;
        step();
        check("bp_b_ready", 64'(out_ready), 64'(1'b0));
        check("bp_b_head",  64'(out_instr), 64'h0010_0093);
        in_instr = 32'h0030_0093; in_pc = 32'h2008;
        for (int i = 0; i < 2; i++) begin
            step();
            check("bp_c_ready", 64'(out_ready), 64'(1'b0));
            check("bp_c_head",  64'(out_instr), 64'h0010_0093);
            check("bp_c_imm",   64'(out_imm),   64'h1);
        end
        ds_ready = 1'b1;
        step();
        check("bp_rel_b",     64'(out_instr), 64'h0020_0093);
        check("bp_rel_b_pc",  64'(out_pc),    64'h2004);
        check("bp_rel_ready", 64'(out_ready), 64'(1'b1));
        step();
        in_valid = 1'b0;
        check("bp_rel_c",    64'(out_instr), 64'h0030_0093);
        check("bp_rel_c_pc", 64'(out_pc),    64'h2008);
        step();
        check("bp_empty", 64'(out_valid), 64'(1'b0));

        // flush from TWO with valid input present
        ds_ready = 1'b0;
        in_valid = 1'b1;
        in_instr = 32'h0040_0093; in_pc = 32'h3000;
        step();
        in_instr = 32'h0050_0093; in_pc = 32'h3004;
        step();
        check("fl_two_ready", 64'(out_ready), 64'(1'b0));
        in_instr = 32'h0060_0093; in_pc = 32'h3008;
        flush = 1'b1;
        step();
        flush = 1'b0;
        in_valid = 1'b0;
        ds_ready = 1'b1;
        check("fl_valid", 64'(out_valid), 64'(1'b0));
        check("fl_ready", 64'(out_ready), 64'(1'b1));
        step();
        check("fl_stay_empty", 64'(out_valid), 64'(1'b0));

        // flush from ONE discards the same-cycle accept
        in_valid = 1'b1;
        in_instr = 32'h0070_0093; in_pc = 32'h3100;
        step();
        in_instr = 32'h0080_0093;
        flush = 1'b1;
        step();
        flush = 1'b0;
        in_valid = 1'b0;
        check("fl1_valid", 64'(out_valid), 64'(1'b0));
        step();
        check("fl1_stay_empty", 64'(out_valid), 64'(1'b0));

        // streaming: one output per cycle, ready never drops
        in_valid = 1'b1;
        in_instr = {12'd0, 5'd0, 3'd0, 5'd1, 7'h13};
        in_pc    = 32'h4000;
        step();
        for (int i = 1; i <= 8; i++) begin
            in_instr = {12'(i), 5'd0, 3'd0, 5'd1, 7'h13};
            in_pc    = 32'h4000 + 32'(i * 4);
            step();
            check("st_valid", 64'(out_valid), 64'(1'b1));
            check("st_ready", 64'(out_ready), 64'(1'b1));
            check("st_imm",   64'(out_imm),   64'(i));
            check("st_pc",    64'(out_pc),    64'(32'h4000 + 32'(i * 4)));
        end
        in_valid = 1'b0;
        step();
        check("st_empty", 64'(out_valid), 64'(1'b0));

        // reset mid-operation ignores a same-cycle accept
        in_valid = 1'b1;
        in_instr = 32'h0090_0093; in_pc = 32'h5000;
        step();
        rst_n = 1'b0;
        step();
        check("mr_valid", 64'(out_valid), 64'(1'b0));
        check("mr_ready", 64'(out_ready), 64'(1'b0));
        check("mr_instr", 64'(out_instr), 64'h0);
        in_valid = 1'b0;
        rst_n = 1'b1;
        step();
        check("mr_rel_valid", 64'(out_valid), 64'(1'b0));
        check("mr_rel_ready", 64'(out_ready), 64'(1'b1));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
